// File: rtl/instr_fetch_pkg.sv
// Shared types for the byte-serial instruction fetch stage.
// Imported by the fetch FSM and its interface users.
package fetch_pkg;

   typedef enum logic [2:0] {
      FETCH_OP,
      LOAD_OP,
      DECODE,
      LOAD_ARG,
      VALID
   } fetch_state_t;

   localparam logic [1:0] ARGC_NONE = 2'd0;
   localparam logic [1:0] ARGC_ONE  = 2'd1;
   localparam logic [1:0] ARGC_TWO  = 2'd2;

   // The decoder may report 3; there are never more than two arg bytes.
   function automatic logic [1:0] clamp_argc(
      input logic [1:0] a
   );
      return (a > ARGC_TWO) ? ARGC_TWO : a;
   endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction hand-off between fetch and execution control.
// The fetch stage is master; execution control is slave.
interface instr_fetch_if #(
   parameter int ADDR_W = 16
);

   logic              instr_valid;
   logic              instr_ready;
   logic [15:0]       instr_args;
   logic [ADDR_W-1:0] instr_addr;
   logic              branch_taken;
   logic [15:0]       branch_offset;

   modport master (
      output instr_valid,
      output instr_args,
      output instr_addr,
      input  instr_ready,
      input  branch_taken,
      input  branch_offset
   );

   modport slave (
      input  instr_valid,
      input  instr_args,
      input  instr_addr,
      output instr_ready,
      output branch_taken,
      output branch_offset
   );

endinterface

// File: rtl/instr_fetch_branch_target.sv
// Branch target: instruction address plus sign-extended offset,
// wrapped modulo 2^ADDR_W.
module branch_target #(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] instr_addr,
   input  logic [15:0]       branch_offset,
   output logic [ADDR_W-1:0] target
);

   localparam int W = (ADDR_W > 16) ? ADDR_W : 16;

   logic [W-1:0] base_x;
   logic [W-1:0] off_x;
   logic [W-1:0] sum;

   assign base_x = W'(instr_addr);
   assign off_x  = W'($signed(branch_offset));
   assign sum    = base_x + off_x;
   assign target = sum[ADDR_W-1:0];

endmodule

// File: rtl/instr_fetch.sv
// Byte-serial fetch: opcode, then 0-2 argument bytes chosen by the
// decoder's argc, then a valid/ready hand-off with optional redirect.
module instr_fetch #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        opcode,
   input  logic [1:0]        argc,
   instr_fetch_if.master     io
);

   import fetch_pkg::*;

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        op_q, op_d;
   logic [15:0]       args_q, args_d;
   logic [1:0]        left_q, left_d;
   logic              valid_q;
   logic [ADDR_W-1:0] target;

   branch_target #(
      .ADDR_W (ADDR_W)
   ) u_target (
      .instr_addr    (addr_q),
      .branch_offset (io.branch_offset),
      .target        (target)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      op_d    = op_q;
      args_d  = args_q;
      left_d  = left_q;
      unique case (state_q)
         FETCH_OP: begin
            addr_d  = ptr_q;
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = LOAD_OP;
         end
         LOAD_OP: begin
            op_d    = mem_rdata;
            args_d  = '0;
            state_d = DECODE;
         end
         DECODE: begin
            if (argc == ARGC_NONE) begin
               state_d = VALID;
            end else begin
               left_d  = clamp_argc(argc);
               ptr_d   = ptr_q + ADDR_W'(1);
               state_d = LOAD_ARG;
            end
         end
         LOAD_ARG: begin
            args_d = {args_q[7:0], mem_rdata};
            left_d = left_q - 2'd1;
            // Last byte lands now; otherwise issue the next read.
            if (left_q == ARGC_ONE) begin
               state_d = VALID;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         VALID: begin
            if (io.instr_ready) begin
               if (io.branch_taken) begin
                  ptr_d = target;
               end
               state_d = FETCH_OP;
            end
         end
         default: begin
            state_d = FETCH_OP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH_OP;
         ptr_q   <= RESET_PC;
         addr_q  <= RESET_PC;
         op_q    <= 8'h00;
         args_q  <= '0;
         left_q  <= ARGC_NONE;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
         args_q  <= args_d;
         left_q  <= left_d;
         valid_q <= (state_d == VALID);
      end
   end

   // Reads are only issued from ptr, so memory always sees ptr.
   assign mem_addr       = ptr_q;
   assign opcode         = op_q;
   assign io.instr_valid = valid_q;
   assign io.instr_args  = args_q;
   assign io.instr_addr  = addr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: latency, args, branch, wrap,
// backpressure and mid-instruction reset.
module tb_instr_fetch;

   logic        clk;
   logic        rst, rst2;
   logic [15:0] mem_addr1, mem_addr2;
   logic [7:0]  rdata1, rdata2;
   logic [7:0]  opcode1, opcode2;
   logic [1:0]  argc1, argc2;
   logic [7:0]  mem [0:65535];

   int n_checks;
   int n_fail;
   int lat;

   instr_fetch_if #(.ADDR_W(16)) if1 ();
   instr_fetch_if #(.ADDR_W(16)) if2 ();

   instr_fetch #(
      .ADDR_W   (16),
      .RESET_PC (16'h0000)
   ) dut1 (
      .clk       (clk),
      .rst       (rst),
      .mem_addr  (mem_addr1),
      .mem_rdata (rdata1),
      .opcode    (opcode1),
      .argc      (argc1),
      .io        (if1)
   );

   instr_fetch #(
      .ADDR_W   (16),
      .RESET_PC (16'hffff)
   ) dut2 (
      .clk       (clk),
      .rst       (rst2),
      .mem_addr  (mem_addr2),
      .mem_rdata (rdata2),
      .opcode    (opcode2),
      .argc      (argc2),
      .io        (if2)
   );

   function automatic logic [1:0] dec_argc(input logic [7:0] op);
      case (op)
         8'h10:        return 2'd1;
         8'h11, 8'ha7: return 2'd2;
         8'h13:        return 2'd3;
         default:      return 2'd0;
      endcase
   endfunction

   assign argc1 = dec_argc(opcode1);
   assign argc2 = dec_argc(opcode2);

   always @(posedge clk) begin
      rdata1 <= mem[mem_addr1];
      rdata2 <= mem[mem_addr2];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input bit sel, input int max,
                             output int n);
      n = 0;
      while (!(sel ? if2.instr_valid : if1.instr_valid) && n < max) begin
         @(negedge clk);
         n++;
      end
      if (!(sel ? if2.instr_valid : if1.instr_valid))
         check("valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst  = 1'b1;
      rst2 = 1'b1;
      if1.instr_ready   = 1'b1;
      if1.branch_taken  = 1'b0;
      if1.branch_offset = 16'h0000;
      if2.instr_ready   = 1'b1;
      if2.branch_taken  = 1'b0;
      if2.branch_offset = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_valid", 32'(if1.instr_valid), 32'd0);
      check("rst_opcode", 32'(opcode1), 32'h00);
      check("rst_args", 32'(if1.instr_args), 32'h0);
      check("rst_iaddr", 32'(if1.instr_addr), 32'h0);
      check("rst_maddr", 32'(mem_addr1), 32'h0);

      // NOP, argc=0
      do_reset();
      wait_valid(0, 20, lat);
      check("nop_lat", lat, 3);
      check("nop_opcode", 32'(opcode1), 32'h00);
      check("nop_iaddr", 32'(if1.instr_addr), 32'h0);
      check("nop_args", 32'(if1.instr_args), 32'h0);
      tick(1);
      check("nop_drop", 32'(if1.instr_valid), 32'd0);
      check("nop_next", 32'(mem_addr1), 32'h1);

      // BIPUSH, argc=1
      mem[0] = 8'h10; mem[1] = 8'h7f;
      do_reset();
      wait_valid(0, 20, lat);
      check("bi_lat", lat, 4);
      check("bi_opcode", 32'(opcode1), 32'h10);
      check("bi_args", 32'(if1.instr_args), 32'h007f);
      check("bi_iaddr", 32'(if1.instr_addr), 32'h0);
      tick(1);
      check("bi_next", 32'(mem_addr1), 32'h2);

      // SIPUSH, argc=2: reads at cycles 0,2,3, valid at 5
      mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34;
      do_reset();
      check("si_ma0", 32'(mem_addr1), 32'h0);
      tick(2);
      check("si_ma2", 32'(mem_addr1), 32'h1);
      tick(1);
      check("si_ma3", 32'(mem_addr1), 32'h2);
      tick(2);
      check("si_valid5", 32'(if1.instr_valid), 32'd1);
      check("si_args", 32'(if1.instr_args), 32'h1234);
      tick(1);
      check("si_next", 32'(mem_addr1), 32'h3);

      // argc=3 behaves as two argument bytes
      mem[0] = 8'h13; mem[1] = 8'hab; mem[2] = 8'hcd;
      do_reset();
      wait_valid(0, 20, lat);
      check("a3_lat", lat, 5);
      check("a3_args", 32'(if1.instr_args), 32'habcd);
      tick(1);
      check("a3_next", 32'(mem_addr1), 32'h3);

      // GOTO -3 from address 5 after five NOPs
      for (int i = 0; i < 5; i++) mem[i] = 8'h00;
      mem[5] = 8'ha7; mem[6] = 8'hff; mem[7] = 8'hfd;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         wait_valid(0, 20, lat);
         tick(1);
      end
      wait_valid(0, 20, lat);
      check("goto_lat", lat, 5);
      check("goto_iaddr", 32'(if1.instr_addr), 32'h5);
      check("goto_args", 32'(if1.instr_args), 32'hfffd);
      if1.branch_taken  = 1'b1;
      if1.branch_offset = 16'hfffd;
      tick(1);
      if1.branch_taken  = 1'b0;
      check("goto_valid", 32'(if1.instr_valid), 32'd0);
      check("goto_tgt", 32'(mem_addr1), 32'h2);

      // Backpressure: held for 4 cycles, then accepted
      mem[0] = 8'h10; mem[1] = 8'h7f;
      if1.instr_ready = 1'b0;
      do_reset();
      wait_valid(0, 20, lat);
      check("bp_lat", lat, 4);
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("bp_valid", 32'(if1.instr_valid), 32'd1);
         check("bp_opcode", 32'(opcode1), 32'h10);
         check("bp_args", 32'(if1.instr_args), 32'h007f);
         check("bp_iaddr", 32'(if1.instr_addr), 32'h0);
         check("bp_maddr", 32'(mem_addr1), 32'h2);
      end
      if1.instr_ready = 1'b1;
      tick(1);
      check("bp_drop", 32'(if1.instr_valid), 32'd0);
      check("bp_next", 32'(mem_addr1), 32'h2);

      // Reset during the second argument load of SIPUSH
      mem[0] = 8'h11; mem[1] = 8'h12; mem[2] = 8'h34;
      do_reset();
      tick(4);
      rst = 1'b1;
      tick(1);
      check("mr_valid", 32'(if1.instr_valid), 32'd0);
      check("mr_opcode", 32'(opcode1), 32'h00);
      check("mr_args", 32'(if1.instr_args), 32'h0);
      check("mr_iaddr", 32'(if1.instr_addr), 32'h0);
      check("mr_maddr", 32'(mem_addr1), 32'h0);
      rst = 1'b0;
      tick(2);
      check("mr_clean", 32'(if1.instr_args), 32'h0);
      tick(3);
      check("mr_refetch", 32'(if1.instr_args), 32'h1234);

      // RESET_PC=ffff: NOP wraps to 0, then GOTO -3 wraps to fffd
      mem[16'hffff] = 8'h00;
      mem[0] = 8'ha7; mem[1] = 8'hff; mem[2] = 8'hfd;
      rst2 = 1'b1;
      tick(1);
      rst2 = 1'b0;
      check("w_maddr", 32'(mem_addr2), 32'hffff);
      wait_valid(1, 20, lat);
      check("w_lat", lat, 3);
      check("w_iaddr", 32'(if2.instr_addr), 32'hffff);
      tick(1);
      check("w_wrap", 32'(mem_addr2), 32'h0);
      wait_valid(1, 20, lat);
      check("w_goto_lat", lat, 5);
      check("w_goto_args", 32'(if2.instr_args), 32'hfffd);
      if2.branch_taken  = 1'b1;
      if2.branch_offset = 16'hfffd;
      tick(1);
      if2.branch_taken  = 1'b0;
      check("w_btgt", 32'(mem_addr2), 32'hfffd);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Byte-serial instruction fetch stage that sits directly upstream of the opcode decoder.
- Reads one byte per request from a synchronous program memory.
- Drives the registered opcode into the decoder and uses the decoder's argc output to collect 0–2 argument bytes.
- Presents a complete instruction (opcode, argument word, instruction address) to execution control over a valid/ready handshake.
- Computes the next fetch address: sequential, or a branch target relative to the instruction address.

Parameters:
ADDR_W, 16, program memory address width; all address arithmetic is modulo 2^ADDR_W.
RESET_PC, 0, first opcode address fetched after reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
mem_addr  out  ADDR_W  program memory byte address (combinational from fetch pointer)
mem_rdata  in  8  memory read data, valid exactly one cycle after mem_addr is presented
opcode  out  8  registered opcode; feeds decoder opcode input
argc  in  2  decoder argc for current opcode (combinational from opcode)
instr_valid  out  1  complete instruction available
instr_ready  in  1  consumer accepts instruction
instr_args  out  16  argument bytes: first byte in [15:8] when argc=2, otherwise the single byte in [7:0]; zero-extended
instr_addr  out  ADDR_W  address of the opcode byte of the presented instruction
branch_taken  in  1  sampled only on handshake; redirect to branch target
branch_offset  in  16  signed offset; the consumer normally drives instr_args here

Behaviour:
- Reset (clk edge with rst=1):
  - state=FETCH_OP, ptr=RESET_PC.
  - instr_valid=0, opcode=8'h00, instr_args=0, instr_addr=RESET_PC, args_left=0.
  - Any in-flight read data is discarded.
- Reset has priority over every other event, including an active handshake and any state (mid-argument included).
- FETCH_OP:
  - mem_addr=ptr; instr_addr<=ptr; ptr<=ptr+1.
  - Next state: LOAD_OP.
- LOAD_OP:
  - opcode<=mem_rdata; instr_args<=0.
  - Next state: DECODE.
- DECODE (argc now valid from opcode):
  - argc=0: next state VALID.
  - Otherwise: args_left<=min(argc,2) (argc=3 is treated as 2); mem_addr=ptr; ptr<=ptr+1; next state LOAD_ARG.
- LOAD_ARG:
  - instr_args<={instr_args[7:0], mem_rdata}; args_left<=args_left-1.
  - args_left=1: next state VALID.
  - Otherwise: issue mem_addr=ptr, ptr<=ptr+1 in the same cycle (back-to-back argument reads), stay in LOAD_ARG.
- VALID:
  - instr_valid=1.
  - opcode, instr_args and instr_addr are held stable while instr_ready=0.
  - No memory reads are issued and ptr is unchanged.
  - On instr_ready=1: if branch_taken, ptr<=instr_addr+sign_extend(branch_offset), truncated to ADDR_W; otherwise ptr is unchanged (already points past the last argument). Next state: FETCH_OP.
- instr_valid is registered (high only in VALID). It drops the cycle after the handshake; there is no back-to-back issue.
- Latency from entering FETCH_OP to instr_valid high:
  - argc=0: 3 cycles.
  - argc=1: 4 cycles.
  - argc=2: 5 cycles.
- Wrap-around: ptr increments past 2^ADDR_W-1 to 0 with no error. Branch targets wrap the same way.
- mem_addr outside FETCH_OP/DECODE/LOAD_ARG issue cycles equals ptr (don't-care to memory, but deterministic).

Decomposition:
- Shared package fetch_pkg:
  - typedef enum fetch_state_t {FETCH_OP, LOAD_OP, DECODE, LOAD_ARG, VALID}.
  - Argc constants ARGC_NONE=0, ARGC_ONE=1, ARGC_TWO=2.
- Sub-module branch_target: combinational signed add of instr_addr and sign-extended 16-bit offset, truncated to ADDR_W. Kept separate so it is unit-testable.
- Everything else (FSM, ptr, argument shift register) lives in instr_fetch.

Test Plan:
- Mem[0]=8'h00 (NOP), decoder argc=0, ready=1 → instr_valid in cycle 3 with opcode=00, instr_addr=0, args=0; next FETCH_OP presents mem_addr=1.
- Mem[0..1]=10 7f (BIPUSH, argc=1) → valid in cycle 4, args=16'h007f, instr_addr=0; next opcode fetch at address 2.
- Mem[0..2]=11 12 34 (SIPUSH, argc=2) → mem_addr sequence 0,1,2 in cycles 0,2,3; valid in cycle 5 with args=16'h1234.
- Mem[5..7]=a7 ff fd (GOTO, offset −3), handshake with branch_taken=1, branch_offset=16'hfffd → next FETCH_OP mem_addr=2. Also cover: RESET_PC=16'hffff with a 1-byte opcode → next fetch wraps to 0.
- Backpressure: hold instr_ready=0 for 4 cycles in VALID → opcode/args/instr_addr/mem_addr unchanged, ptr unchanged; accept on cycle 5, then instr_valid=0 the following cycle.
- Assert rst during second LOAD_ARG of SIPUSH → next cycle state FETCH_OP, mem_addr=RESET_PC, instr_valid=0, opcode=00, args=0; the stale mem_rdata never appears in instr_args.
